// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_pkg
// Description : Shared types and default constants for the programmable
//               clock divider controller (state encoding, widths, defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

    // Default width of the half-period register and the phase counter
    localparam int unsigned c_cnt_w               = 16;
    // Half-period loaded at reset, in system clock cycles (must be >= 1)
    localparam int unsigned c_default_half_period = 5;
    // Width of the optional rising-edge counter
    localparam int unsigned c_edge_cnt_w          = 32;

    // Controller sequencer states
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

endpackage : clkdiv_pkg
`default_nettype wire

// File: rtl/clkdiv_counter.sv
`default_nettype none
// ============================================================================
// Module      : clkdiv_counter
// Description : Phase counter for the clock divider. Counts cycles within the
//               current half-period, flags the terminal count and wraps to
//               zero on it; a synchronous clear holds it at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module clkdiv_counter
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W = c_cnt_w
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [CNT_W-1:0] i_hp,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_last;

    // Half-period is never zero, so hp-1 cannot underflow
    assign w_last = i_hp - CNT_W'(1);
    assign o_tc   = (r_cnt == w_last);

    // Count while enabled, wrap at terminal count, clear on request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || (i_en && o_tc)) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule : clkdiv_counter
`default_nettype wire

// File: rtl/clock_divider_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_divider_ctrl
// Description : Runtime-programmable divided clock generator with start/stop
//               sequencing, valid/ready half-period configuration and
//               registered edge strobes. clk_out has period 2*half-period and
//               50% duty; every high phase uses a single half-period value.
//               Optional feature macro: CLKDIV_EDGE_CNT_EN adds a 32-bit
//               rising-edge counter output (edge_count).
// Revision    : 1.0 - initial release
// ============================================================================
module clock_divider_ctrl
    import clkdiv_pkg::*;
#(
    parameter int unsigned CNT_W               = c_cnt_w,
    parameter int unsigned DEFAULT_HALF_PERIOD = c_default_half_period
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CNT_W-1:0]        cfg_half_period,
    output logic                    clk_out,
    output logic                    tick_rise,
    output logic                    tick_fall,
    output logic                    running
`ifdef CLKDIV_EDGE_CNT_EN
    ,
    output logic [c_edge_cnt_w-1:0] edge_count
`endif
);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_clk_out;
    logic             r_tick_rise;
    logic             r_tick_fall;
    logic [CNT_W-1:0] r_hp;
    logic [CNT_W-1:0] r_pend_hp;
    logic             r_pend_vld;
    logic [CNT_W-1:0] w_cfg_hp;
    logic             w_cfg_fire;
    logic             w_tc;
    logic             w_toggle;
    logic             w_rise;
    logic             w_fall;
    logic             w_to_idle;

    // A zero half-period would never reach terminal count; treat it as 1
    assign w_cfg_hp   = (cfg_half_period == '0) ? CNT_W'(1) : cfg_half_period;
    assign cfg_ready  = ~r_pend_vld;
    assign w_cfg_fire = cfg_valid & ~r_pend_vld;

    assign w_rise    = w_toggle & ~r_clk_out;
    assign w_fall    = w_toggle &  r_clk_out;
    assign w_to_idle = (w_state_next == IDLE);

    clkdiv_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (r_state != IDLE),
        .i_clr (w_to_idle),
        .i_hp  (r_hp),
        .o_tc  (w_tc)
    );

    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and toggle decision; stop in the low phase wins over a rise
    always_comb begin
        w_state_next = r_state;
        w_toggle     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !stop) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (stop && !r_clk_out) begin
                    w_state_next = IDLE;
                end else begin
                    w_toggle = w_tc;
                    if (stop) begin
                        // High phase: finish it; leave directly if it ends now
                        w_state_next = w_tc ? IDLE : STOPPING;
                    end
                end
            end
            STOPPING: begin
                if (w_tc) begin
                    w_toggle     = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Registered divided clock and its edge strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_out   <= 1'b0;
            r_tick_rise <= 1'b0;
            r_tick_fall <= 1'b0;
        end else begin
            r_clk_out   <= r_clk_out ^ w_toggle;
            r_tick_rise <= w_rise;
            r_tick_fall <= w_fall;
        end
    end

    // Half-period register and one-entry pending slot; changes take effect
    // only at a falling edge or on entry to IDLE so a high phase never splits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hp       <= CNT_W'(DEFAULT_HALF_PERIOD);
            r_pend_hp  <= '0;
            r_pend_vld <= 1'b0;
        end else if (r_state == IDLE) begin
            if (w_cfg_fire) begin
                r_hp <= w_cfg_hp;
            end
        end else if (r_pend_vld) begin
            if (w_fall || w_to_idle) begin
                r_hp       <= r_pend_hp;
                r_pend_vld <= 1'b0;
            end
        end else if (w_cfg_fire) begin
            if (w_to_idle) begin
                r_hp <= w_cfg_hp;
            end else begin
                r_pend_hp  <= w_cfg_hp;
                r_pend_vld <= 1'b1;
            end
        end
    end

    assign clk_out   = r_clk_out;
    assign tick_rise = r_tick_rise;
    assign tick_fall = r_tick_fall;
    assign running   = (r_state != IDLE);

`ifdef CLKDIV_EDGE_CNT_EN
    logic [c_edge_cnt_w-1:0] r_edge_count;

    // Rising edges since the last start; wraps naturally at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_count <= '0;
        end else if ((r_state == IDLE) && (w_state_next == RUN)) begin
            r_edge_count <= '0;
        end else if (w_rise) begin
            r_edge_count <= r_edge_count + c_edge_cnt_w'(1);
        end
    end

    assign edge_count = r_edge_count;
`endif

endmodule : clock_divider_ctrl
`default_nettype wire

// File: tb/tb_clock_divider_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_divider_ctrl
// Description : Self-checking bench for clock_divider_ctrl. Phase lengths are
//               measured in clk cycles and compared with the half-period the
//               programming rules say must be in force.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_divider_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_half_period = '0;
    logic        cfg_ready;
    logic        clk_out;
    logic        tick_rise;
    logic        tick_fall;
    logic        running;
`ifdef CLKDIV_EDGE_CNT_EN
    logic [31:0] edge_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] cfg;
        int          exp_hp;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    clock_divider_ctrl #(
        .CNT_W               (16),
        .DEFAULT_HALF_PERIOD (5)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .stop            (stop),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_half_period (cfg_half_period),
        .clk_out         (clk_out),
        .tick_rise       (tick_rise),
        .tick_fall       (tick_fall),
        .running         (running)
`ifdef CLKDIV_EDGE_CNT_EN
        ,
        .edge_count      (edge_count)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Cycles until clk_out reaches lvl (bounded)
    task automatic wait_level(input logic lvl, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (clk_out !== lvl && n < 100);
    endtask

    task automatic cfg_idle(input logic [15:0] v);
        check("cfg_ready_idle", cfg_ready, 1);
        cfg_valid       = 1'b1;
        cfg_half_period = v;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("running_after_start", running, 1);
    endtask

    // Must be called while clk_out is low in RUN
    task automatic stop_low();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_low_running", running, 0);
        check("stop_low_clk_out", clk_out, 0);
    endtask

    // Random program/run/reprogram/stop; expected phase lengths come from the
    // rule that a mid-run value first governs the low phase after the next fall
    task automatic random_run();
        int va, vb, ea, eb, nph, kc, len, n, s, rises, exp_len;
        logic lvl;
        logic in_high;
        va    = int'($urandom_range(0, 6));
        vb    = int'($urandom_range(0, 6));
        ea    = (va == 0) ? 1 : va;
        eb    = (vb == 0) ? 1 : vb;
        nph   = int'($urandom_range(4, 9));
        kc    = 2 * int'($urandom_range(1, (nph - 1) / 2));
        rises = 0;
        cfg_idle(16'(va));
        do_start();
        for (int p = 0; p < nph; p++) begin
            lvl     = (p % 2 == 0) ? 1'b1 : 1'b0;
            exp_len = (p < kc + 2) ? ea : eb;
            if (p == kc) begin
                check("rnd_cfg_ready", cfg_ready, 1);
                cfg_valid       = 1'b1;
                cfg_half_period = 16'(vb);
            end
            n = 0;
            do begin
                tick();
                cfg_valid = 1'b0;
                n++;
            end while (clk_out !== lvl && n < 100);
            check("rnd_phase_len", n, exp_len);
            if (lvl) rises++;
        end
        in_high = (nph % 2 == 1);
        len     = (nph < kc + 2) ? ea : eb;
        s       = int'($urandom_range(0, len - 1));
        repeat (s) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n = s + 1;
        if (in_high) begin
            while (clk_out !== 1'b0 && n < 100) begin
                tick();
                n++;
            end
            check("rnd_stop_high_len", n, len);
        end
        check("rnd_stop_running", running, 0);
        check("rnd_stop_clk_out", clk_out, 0);
`ifdef CLKDIV_EDGE_CNT_EN
        check("rnd_edge_count", edge_count, rises);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{16'd0, 1};
        vecs[1] = '{16'd1, 1};
        vecs[2] = '{16'd2, 2};
        vecs[3] = '{16'd3, 3};
        vecs[4] = '{16'd7, 7};
        vecs[5] = '{16'd12, 12};

        // Reset values
        repeat (3) tick();
        check("rst_clk_out", clk_out, 0);
        check("rst_tick_rise", tick_rise, 0);
        check("rst_tick_fall", tick_fall, 0);
        check("rst_running", running, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        rst_n = 1'b1;
        tick();

        // Default half-period 5: 4 full periods
        do_start();
        wait_level(1'b1, n);
        check("dflt_first_rise", n, 5);
        check("dflt_tick_rise", tick_rise, 1);
        for (int i = 0; i < 4; i++) begin
            wait_level(1'b0, n);
            check("dflt_high", n, 5);
            check("dflt_tick_fall", tick_fall, 1);
            wait_level(1'b1, n);
            check("dflt_low", n, 5);
        end
        wait_level(1'b0, n);
        stop_low();

        // Table of configurations programmed in IDLE
        foreach (vecs[i]) begin
            cfg_idle(vecs[i].cfg);
            do_start();
            wait_level(1'b1, n);
            check("tbl_first_rise", n, vecs[i].exp_hp);
            wait_level(1'b0, n);
            check("tbl_high", n, vecs[i].exp_hp);
            wait_level(1'b1, n);
            check("tbl_low", n, vecs[i].exp_hp);
            wait_level(1'b0, n);
            check("tbl_high2", n, vecs[i].exp_hp);
            stop_low();
        end

        // Half-period 0 -> clk/2, strobes alternate every cycle
        cfg_idle(16'd0);
        do_start();
        wait_level(1'b1, n);
        check("div2_first_rise", n, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("div2_clk_out", clk_out, (i % 2 == 0) ? 0 : 1);
            check("div2_tick_rise", tick_rise, (i % 2 == 0) ? 0 : 1);
            check("div2_tick_fall", tick_fall, (i % 2 == 0) ? 1 : 0);
        end
        tick();
        stop_low();

        // Mid-high-phase reconfiguration with a second, stalled offer
        cfg_idle(16'd4);
        do_start();
        wait_level(1'b1, n);
        check("mc_first_rise", n, 4);
        tick();
        cfg_valid       = 1'b1;
        cfg_half_period = 16'd7;
        tick();
        cfg_half_period = 16'd9;
        check("mc_ready_pending", cfg_ready, 0);
        tick();
        check("mc_ready_pending2", cfg_ready, 0);
        check("mc_still_high", clk_out, 1);
        tick();
        check("mc_fall_at_4", clk_out, 0);
        check("mc_tick_fall", tick_fall, 1);
        check("mc_ready_freed", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        check("mc_second_accepted", cfg_ready, 0);
        wait_level(1'b1, n);
        check("mc_low_7", n + 1, 7);
        wait_level(1'b0, n);
        check("mc_high_7", n, 7);
        wait_level(1'b1, n);
        check("mc_low_9", n, 9);
        wait_level(1'b0, n);
        check("mc_high_9", n, 9);
        stop_low();

        // Stop during high phase: full high phase, then IDLE
        cfg_idle(16'd6);
        do_start();
        wait_level(1'b1, n);
        check("sh_first_rise", n, 6);
        tick();
        tick();
        stop  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sh_running_stopping", running, 1);
        check("sh_clk_still_high", clk_out, 1);
        wait_level(1'b0, n);
        stop = 1'b0;
        check("sh_rest_of_high", n, 3);
        check("sh_tick_fall", tick_fall, 1);
        check("sh_running_off", running, 0);
        tick();
        check("sh_tick_fall_pulse", tick_fall, 0);
        check("sh_idle_clk_out", clk_out, 0);
        check("sh_idle_running", running, 0);

        // start and stop together in IDLE: stop wins
        start = 1'b1;
        stop  = 1'b1;
        tick();
        check("ss_running", running, 0);
        tick();
        check("ss_running2", running, 0);
        check("ss_clk_out", clk_out, 0);
        start = 1'b0;
        stop  = 1'b0;
        tick();

        // Randomized runs
        for (int r = 0; r < 15; r++) begin
            random_run();
            tick();
        end

`ifdef CLKDIV_EDGE_CNT_EN
        // Edge counter: 10 periods, then cleared on restart
        cfg_idle(16'd1);
        do_start();
        check("ec_start_zero", edge_count, 0);
        for (int i = 0; i < 10; i++) begin
            wait_level(1'b1, n);
            wait_level(1'b0, n);
        end
        check("ec_ten", edge_count, 10);
        stop_low();
        do_start();
        check("ec_cleared", edge_count, 0);
        wait_level(1'b1, n);
        check("ec_one", edge_count, 1);
        wait_level(1'b0, n);
        stop_low();
`endif

        // Asynchronous reset in mid-high phase with a pending value
        cfg_idle(16'd9);
        do_start();
        wait_level(1'b1, n);
        check("rr_first_rise", n, 9);
        tick();
        cfg_valid       = 1'b1;
        cfg_half_period = 16'd3;
        tick();
        cfg_valid = 1'b0;
        check("rr_pending", cfg_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rr_async_clk_out", clk_out, 0);
        check("rr_async_ready", cfg_ready, 1);
        check("rr_async_running", running, 0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        wait_level(1'b1, n);
        check("rr_default_restored", n, 5);
        wait_level(1'b0, n);
        check("rr_default_high", n, 5);
        stop_low();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_clock_divider_ctrl
`default_nettype wire
